// File: rtl/c64_bus_arbiter.sv
// Purpose : shares the system memory bus between the 6502 core, the video fetch unit and an
//           expansion DMA port. Video owns every phi1 half-cycle; phi2 goes to CPU, video or DMA.
// Latency : bus outputs are combinational from phase/state; ownership changes at the end of phi2.
// Backpressure: the CPU is stalled by withholding o_cpu_ce; video gets a BA warning of BA_DELAY
//           slots before a steal, and DMA bursts are capped at DMA_MAX_BURST slots.
//
// Ports:
//   i_clk, i_reset (async, active-low)        clock / reset; two clocks form one bus cycle
//   i_cpu_ab/do/we, o_cpu_ce                   CPU request and clock enable (one-clock pulse)
//   i_vid_ab, i_vid_steal, o_vid_gnt           video fetch address, phi2 steal request, grant
//   i_dma_req, i_dma_ab/do/we, o_dma_gnt       DMA request, address/data/write, grant
//   o_ba, o_phase                              bus-available warning, 0 = phi1 / 1 = phi2
//   o_mem_ab/do/we                             muxed memory bus

module c64_bus_arbiter #(
    parameter int BA_DELAY      = 3,
    parameter int DMA_MAX_BURST = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_cpu_ab,
    input  logic [7:0]  i_cpu_do,
    input  logic        i_cpu_we,
    output logic        o_cpu_ce,
    input  logic [15:0] i_vid_ab,
    input  logic        i_vid_steal,
    output logic        o_vid_gnt,
    input  logic        i_dma_req,
    input  logic [15:0] i_dma_ab,
    input  logic [7:0]  i_dma_do,
    input  logic        i_dma_we,
    output logic        o_dma_gnt,
    output logic        o_ba,
    output logic        o_phase,
    output logic [15:0] o_mem_ab,
    output logic [7:0]  o_mem_do,
    output logic        o_mem_we
);

    localparam int BA_CNT_W = $clog2(BA_DELAY + 1);
    localparam int BURST_W  = $clog2(DMA_MAX_BURST + 1);

    localparam logic [BA_CNT_W-1:0] BA_INIT   = BA_CNT_W'(BA_DELAY);
    localparam logic [BA_CNT_W-1:0] BA_ONE    = BA_CNT_W'(1);
    localparam logic [BURST_W-1:0]  BURST_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0]  BURST_MAX = BURST_W'(DMA_MAX_BURST);

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_BA_WAIT = 2'd1,
        S_VID     = 2'd2,
        S_DMA     = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_phase;
    logic                  r_ba;
    logic [BA_CNT_W-1:0]   r_ba_cnt;
    logic [BURST_W-1:0]    r_burst_cnt;

    logic [15:0] w_mem_ab;
    logic [7:0]  w_mem_do;
    logic        w_mem_we;
    logic        w_cpu_ce;
    logic        w_vid_gnt;
    logic        w_dma_gnt;

    // Ownership only changes on the edge that ends phi2; requests seen at a phi1 edge are ignored.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_phase     <= 1'b0;
            r_state     <= S_CPU;
            r_ba        <= 1'b1;
            r_ba_cnt    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                case (r_state)
                    S_CPU: begin
                        if (i_vid_steal) begin
                            r_state  <= S_BA_WAIT;
                            r_ba_cnt <= BA_INIT;
                            r_ba     <= 1'b0;
                        end else if (i_dma_req) begin
                            r_state     <= S_DMA;
                            r_burst_cnt <= BURST_ONE;
                        end
                    end
                    S_BA_WAIT: begin
                        if (!i_vid_steal) begin
                            // Steal abandoned before video took the bus.
                            r_state <= S_CPU;
                            r_ba    <= 1'b1;
                        end else if (r_ba_cnt == BA_ONE) begin
                            r_state <= S_VID;
                        end else begin
                            r_ba_cnt <= r_ba_cnt - BA_ONE;
                        end
                    end
                    S_VID: begin
                        if (!i_vid_steal) begin
                            r_ba <= 1'b1;
                            if (i_dma_req) begin
                                r_state     <= S_DMA;
                                r_burst_cnt <= BURST_ONE;
                            end else begin
                                r_state <= S_CPU;
                            end
                        end
                    end
                    S_DMA: begin
                        if (i_vid_steal) begin
                            // DMA has no RDY hold-off to respect, so video preempts at once.
                            r_state <= S_VID;
                            r_ba    <= 1'b0;
                        end else if (!i_dma_req) begin
                            r_state <= S_CPU;
                        end else if (r_burst_cnt == BURST_MAX) begin
                            // Capped burst: hand exactly one slot back to the CPU.
                            r_state <= S_CPU;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + BURST_ONE;
                        end
                    end
                    default: r_state <= S_CPU;
                endcase
            end
        end
    end

    // Bus mux. Held at idle values while reset is asserted so no grant or write leaks out.
    always_comb begin
        w_mem_ab  = i_vid_ab;
        w_mem_do  = i_cpu_do;
        w_mem_we  = 1'b0;
        w_cpu_ce  = 1'b0;
        w_vid_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (i_reset) begin
            if (!r_phase) begin
                w_vid_gnt = 1'b1;
            end else begin
                case (r_state)
                    S_CPU: begin
                        w_mem_ab = i_cpu_ab;
                        w_mem_do = i_cpu_do;
                        w_mem_we = i_cpu_we;
                        w_cpu_ce = 1'b1;
                    end
                    S_BA_WAIT: begin
                        // A 6502 write cannot be held, so it completes; a read just waits.
                        w_mem_ab = i_cpu_ab;
                        w_mem_do = i_cpu_do;
                        w_mem_we = i_cpu_we;
                        w_cpu_ce = i_cpu_we;
                    end
                    S_VID: begin
                        w_vid_gnt = 1'b1;
                    end
                    S_DMA: begin
                        w_dma_gnt = 1'b1;
                        w_mem_ab  = i_dma_ab;
                        w_mem_do  = i_dma_do;
                        w_mem_we  = i_dma_we;
                    end
                    default: begin
                        w_mem_ab = i_vid_ab;
                    end
                endcase
            end
        end
    end

    assign o_mem_ab  = w_mem_ab;
    assign o_mem_do  = w_mem_do;
    assign o_mem_we  = w_mem_we;
    assign o_cpu_ce  = w_cpu_ce;
    assign o_vid_gnt = w_vid_gnt;
    assign o_dma_gnt = w_dma_gnt;
    assign o_ba      = r_ba;
    assign o_phase   = r_phase;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Purpose : directed stimulus for c64_bus_arbiter; expected bus state for every half-cycle is
//           queued by the stimulus and compared by an independent monitor on the falling edge.
// Latency : one queue entry per half-cycle, checked mid-half-cycle.
// Backpressure: none; the queue must be empty at the end of the run.

module tb_c64_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic        cpu_ce;
    logic [15:0] vid_ab;
    logic        vid_steal;
    logic        vid_gnt;
    logic        dma_req;
    logic [15:0] dma_ab;
    logic [7:0]  dma_do;
    logic        dma_we;
    logic        dma_gnt;
    logic        ba;
    logic        phase;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;

    always #5 clk = ~clk;

    c64_bus_arbiter #(.BA_DELAY(3), .DMA_MAX_BURST(8)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_cpu_ab   (cpu_ab),
        .i_cpu_do   (cpu_do),
        .i_cpu_we   (cpu_we),
        .o_cpu_ce   (cpu_ce),
        .i_vid_ab   (vid_ab),
        .i_vid_steal(vid_steal),
        .o_vid_gnt  (vid_gnt),
        .i_dma_req  (dma_req),
        .i_dma_ab   (dma_ab),
        .i_dma_do   (dma_do),
        .i_dma_we   (dma_we),
        .o_dma_gnt  (dma_gnt),
        .o_ba       (ba),
        .o_phase    (phase),
        .o_mem_ab   (mem_ab),
        .o_mem_do   (mem_do),
        .o_mem_we   (mem_we)
    );

    typedef struct packed {
        logic [7:0]  tid;
        logic [15:0] vnum;
        logic        ph;
        logic        ba;
        logic        ce;
        logic        vg;
        logic        dg;
        logic        we;
        logic        chk_ab;
        logic        chk_do;
        logic [15:0] ab;
        logic [7:0]  dat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         vec_id = 0;
    logic [7:0] cur_tid = 8'd0;

    function automatic exp_t mk(input logic ph, input logic b, input logic ce, input logic vg,
                                input logic dg, input logic we, input logic cab, input logic cdo,
                                input logic [15:0] ab, input logic [7:0] dat);
        exp_t e;
        e.tid = cur_tid; e.vnum = 16'd0;
        e.ph = ph; e.ba = b; e.ce = ce; e.vg = vg; e.dg = dg; e.we = we;
        e.chk_ab = cab; e.chk_do = cdo; e.ab = ab; e.dat = dat;
        return e;
    endfunction

    // Expected views of the bus for each kind of half-cycle.
    function automatic exp_t p1(input logic b);
        return mk(1'b0, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, vid_ab, 8'h00);
    endfunction
    function automatic exp_t cpu(input logic b);
        return mk(1'b1, b, 1'b1, 1'b0, 1'b0, cpu_we, 1'b1, cpu_we, cpu_ab, cpu_do);
    endfunction
    function automatic exp_t idle();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endfunction
    function automatic exp_t vid();
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, vid_ab, 8'h00);
    endfunction
    function automatic exp_t dma(input logic b);
        return mk(1'b1, b, 1'b0, 1'b0, 1'b1, dma_we, 1'b1, dma_we, dma_ab, dma_do);
    endfunction

    // One half-cycle: apply requests just after the edge, queue what the bus must show.
    task automatic half(input logic vs, input logic dr, input exp_t e);
        @(posedge clk);
        #1;
        vid_steal = vs;
        dma_req   = dr;
        e.vnum    = vec_id[15:0];
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", nm, got, want);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_phase", {31'd0, phase}, 32'd0);
        chk("post_rst_vid_gnt", {31'd0, vid_gnt}, 32'd1);
        chk("post_rst_ba", {31'd0, ba}, 32'd1);
    endtask

    // Monitor: independent of stimulus, compares one queued entry per falling edge.
    exp_t mon_e;
    logic mon_ok;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            mon_ok = (phase == mon_e.ph) && (ba == mon_e.ba) && (cpu_ce == mon_e.ce) &&
                     (vid_gnt == mon_e.vg) && (dma_gnt == mon_e.dg) && (mem_we == mon_e.we) &&
                     (!mon_e.chk_ab || mem_ab == mon_e.ab) && (!mon_e.chk_do || mem_do == mon_e.dat);
            n_chk++;
            if (mon_ok) n_pass++;
            else $display("FAIL t%0d v%0d got ph=%b ba=%b ce=%b vg=%b dg=%b we=%b ab=%h do=%h want ph=%b ba=%b ce=%b vg=%b dg=%b we=%b ab=%h do=%h",
                          mon_e.tid, mon_e.vnum, phase, ba, cpu_ce, vid_gnt, dma_gnt, mem_we, mem_ab, mem_do,
                          mon_e.ph, mon_e.ba, mon_e.ce, mon_e.vg, mon_e.dg, mon_e.we, mon_e.ab, mon_e.dat);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Steal sequence: sampling slot, 3 BA_WAIT slots, 7 VID slots (last with steal dropped).
    task automatic steal_seq();
        half(1'b1, 1'b0, cpu(1'b1));
        half(1'b1, 1'b0, p1(1'b0));
        for (int i = 0; i < 3; i++) begin
            half(1'b1, 1'b0, cpu_we ? cpu(1'b0) : idle());
            half(1'b1, 1'b0, p1(1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            half(1'b1, 1'b0, vid());
            half(1'b1, 1'b0, p1(1'b0));
        end
        half(1'b0, 1'b0, vid());
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));
    endtask

    initial begin
        rst_n = 1'b0; vid_steal = 1'b0; dma_req = 1'b0;
        cpu_ab = 16'h1234; cpu_do = 8'hAA; cpu_we = 1'b0;
        vid_ab = 16'h3C00; dma_ab = 16'h8000; dma_do = 8'h5A; dma_we = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_phase", {31'd0, phase}, 32'd0);
        chk("rst_ba", {31'd0, ba}, 32'd1);
        chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        chk("rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        release_rst();

        // 1: idle, CPU owns every phi2
        cur_tid = 8'd1;
        for (int i = 0; i < 4; i++) begin
            half(1'b0, 1'b0, cpu(1'b1));
            half(1'b0, 1'b0, p1(1'b1));
        end

        // 2: requests visible only at a phi1 edge are ignored
        cur_tid = 8'd2;
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b1, 1'b1, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        // 3: video steal with CPU reading
        cur_tid = 8'd3;
        steal_seq();

        // 4: video steal with CPU writing during BA_WAIT
        cur_tid = 8'd4;
        cpu_we = 1'b1; cpu_ab = 16'hD020; cpu_do = 8'h05;
        steal_seq();
        cpu_we = 1'b0; cpu_ab = 16'h1234; cpu_do = 8'hAA;

        // 5: video and DMA rise together, video wins; then steal abandoned
        cur_tid = 8'd5;
        half(1'b1, 1'b1, cpu(1'b1));
        half(1'b1, 1'b1, p1(1'b0));
        half(1'b0, 1'b0, idle());
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        // 6: DMA held 20 bus cycles: 8 DMA slots then 1 CPU slot, repeating; drop mid-burst
        cur_tid = 8'd6;
        for (int s = 0; s < 20; s++) begin
            half(1'b0, 1'b1, (s % 9 == 0) ? cpu(1'b1) : dma(1'b1));
            half(1'b0, 1'b1, p1(1'b1));
        end
        half(1'b0, 1'b0, dma(1'b1));
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        // 7: video preempts a DMA burst without BA delay; DMA resumes with a fresh burst
        cur_tid = 8'd7;
        half(1'b0, 1'b1, cpu(1'b1));
        half(1'b0, 1'b1, p1(1'b1));
        for (int i = 0; i < 2; i++) begin
            half(1'b0, 1'b1, dma(1'b1));
            half(1'b0, 1'b1, p1(1'b1));
        end
        half(1'b1, 1'b1, dma(1'b1));
        half(1'b1, 1'b1, p1(1'b0));
        half(1'b1, 1'b1, vid());
        half(1'b1, 1'b1, p1(1'b0));
        half(1'b0, 1'b1, vid());
        half(1'b0, 1'b1, p1(1'b1));
        for (int i = 0; i < 8; i++) begin
            half(1'b0, 1'b1, dma(1'b1));
            half(1'b0, 1'b1, p1(1'b1));
        end
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        // 8: one-cycle steal pulse abandoned, then reset asserted in the middle of a VID slot
        cur_tid = 8'd8;
        half(1'b1, 1'b0, cpu(1'b1));
        half(1'b1, 1'b0, p1(1'b0));
        half(1'b0, 1'b0, idle());
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));
        half(1'b1, 1'b0, cpu(1'b1));
        half(1'b1, 1'b0, p1(1'b0));
        for (int i = 0; i < 3; i++) begin
            half(1'b1, 1'b0, idle());
            half(1'b1, 1'b0, p1(1'b0));
        end
        half(1'b1, 1'b0, vid());
        @(negedge clk);
        #1;
        rst_n = 1'b0; vid_steal = 1'b0;
        #1;
        chk("vid_rst_ba", {31'd0, ba}, 32'd1);
        chk("vid_rst_vid_gnt", {31'd0, vid_gnt}, 32'd0);
        chk("vid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("vid_rst_phase", {31'd0, phase}, 32'd0);
        repeat (2) @(negedge clk);
        release_rst();
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        // 9: reset asserted during a DMA write slot
        cur_tid = 8'd9;
        half(1'b0, 1'b1, cpu(1'b1));
        half(1'b0, 1'b1, p1(1'b1));
        half(1'b0, 1'b1, dma(1'b1));
        @(negedge clk);
        #1;
        rst_n = 1'b0; dma_req = 1'b0;
        #1;
        chk("dma_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("dma_rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("dma_rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
        repeat (2) @(negedge clk);
        release_rst();
        half(1'b0, 1'b0, cpu(1'b1));
        half(1'b0, 1'b0, p1(1'b1));

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
